// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: state encoding, widths and the
// elaboration-time integer-to-BCD helper used for phase load values.
package wash_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 4 * DIGIT_W;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_ALARM = 3'd5
    } state_e;

    function automatic logic [BCD_W-1:0] to_bcd16(input int v);
        return {DIGIT_W'((v / 1000) % 10), DIGIT_W'((v / 100) % 10),
                DIGIT_W'((v / 10) % 10), DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/wash_sequencer_bcd_down4.sv
// Four-digit BCD down-counter register with synchronous load and decrement;
// is_one flags the last second of a phase.
module bcd_down4
    import wash_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             is_one
);

    logic [BCD_W-1:0] val_q, val_d, dec_val;
    logic             borrow;

    // Borrow ripples upward: a zero digit wraps to 9 and keeps borrowing.
    always_comb begin
        dec_val = val_q;
        borrow  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (val_q[i*DIGIT_W +: DIGIT_W] == '0) begin
                    dec_val[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(9);
                end else begin
                    dec_val[i*DIGIT_W +: DIGIT_W] = val_q[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        val_d = val_q;
        if (load)     val_d = load_val;
        else if (dec) val_d = dec_val;
    end

    always_ff @(posedge clk) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
    end

    assign value  = val_q;
    assign is_one = (val_q == BCD_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: FILL -> WASH -> SPIN -> (FILL -> RINSE -> SPIN) x RINSES
// -> ALARM -> IDLE, timed by a one-second tick prescaler off the single clock.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 24_000_000,
    parameter int FILL_T   = 60,
    parameter int WASH_T   = 30,
    parameter int RINSE_T  = 20,
    parameter int SPIN_T   = 10,
    parameter int ALARM_T  = 5,
    parameter int RINSES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               waterfull,
    output logic [STATE_W-1:0] state,
    output logic [5:0]         state_led,
    output logic [BCD_W-1:0]   bcd,
    output logic [3:0]         rinse_left,
    output logic               paused,
    output logic               fault,
    output logic               done
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [BCD_W-1:0] FILL_BCD  = to_bcd16(FILL_T);
    localparam logic [BCD_W-1:0] WASH_BCD  = to_bcd16(WASH_T);
    localparam logic [BCD_W-1:0] RINSE_BCD = to_bcd16(RINSE_T);
    localparam logic [BCD_W-1:0] SPIN_BCD  = to_bcd16(SPIN_T);
    localparam logic [BCD_W-1:0] ALARM_BCD = to_bcd16(ALARM_T);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rinse_q, rinse_d;
    logic             washed_q, washed_d;
    logic             paused_q, paused_d;
    logic             fault_q, fault_d;
    logic             done_q, done_d;

    logic             tick, expire;
    logic             bcd_load, bcd_dec, bcd_is_one;
    logic [BCD_W-1:0] bcd_load_val, bcd_val;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rinse_d      = rinse_q;
        washed_d     = washed_q;
        paused_d     = paused_q;
        fault_d      = fault_q;
        done_d       = 1'b0;
        bcd_load     = 1'b0;
        bcd_load_val = '0;
        bcd_dec      = 1'b0;
        tick         = (state_q != S_IDLE) && !paused_q && (cnt_q == CNT_MAX);
        expire       = tick && bcd_is_one;

        if (stop && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            rinse_d  = '0;
            paused_d = 1'b0;
            bcd_load = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d  = S_FILL;
                    rinse_d  = 4'(RINSES);
                    fault_d  = 1'b0;
                    washed_d = 1'b0;
                    paused_d = 1'b0;
                end
                S_FILL: begin
                    // The tank-full exit wins over a coincident timeout and is honoured while paused.
                    if (waterfull) state_d = washed_q ? S_RINSE : S_WASH;
                    else if (expire) begin
                        state_d = S_ALARM;
                        fault_d = 1'b1;
                    end
                end
                S_WASH: if (expire) begin
                    state_d  = S_SPIN;
                    washed_d = 1'b1;
                end
                S_RINSE: if (expire) begin
                    state_d = S_SPIN;
                    rinse_d = rinse_q - 4'd1;
                end
                S_SPIN: if (expire) state_d = (rinse_q != '0) ? S_FILL : S_ALARM;
                S_ALARM: if (expire) begin
                    state_d = S_IDLE;
                    done_d  = !fault_q;
                end
                default: state_d = S_IDLE;
            endcase

            if (state_d != state_q) begin
                cnt_d    = '0;
                bcd_load = 1'b1;
                case (state_d)
                    S_FILL:  bcd_load_val = FILL_BCD;
                    S_WASH:  bcd_load_val = WASH_BCD;
                    S_RINSE: bcd_load_val = RINSE_BCD;
                    S_SPIN:  bcd_load_val = SPIN_BCD;
                    S_ALARM: bcd_load_val = ALARM_BCD;
                    default: bcd_load_val = '0;
                endcase
            end else if (tick) begin
                cnt_d   = '0;
                bcd_dec = 1'b1;
            end else if (state_q != S_IDLE && !paused_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (pause && state_q != S_IDLE) paused_d = !paused_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rinse_q  <= '0;
            washed_q <= 1'b0;
            paused_q <= 1'b0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rinse_q  <= rinse_d;
            washed_q <= washed_d;
            paused_q <= paused_d;
            fault_q  <= fault_d;
            done_q   <= done_d;
        end
    end

    bcd_down4 u_bcd (
        .clk      (clk),
        .reset    (reset),
        .load     (bcd_load),
        .load_val (bcd_load_val),
        .dec      (bcd_dec),
        .value    (bcd_val),
        .is_one   (bcd_is_one)
    );

    assign state      = state_q;
    assign state_led  = 6'(1) << state_q;
    assign bcd        = bcd_val;
    assign rinse_left = rinse_q;
    assign paused     = paused_q;
    assign fault      = fault_q;
    assign done       = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench: two configurations share stimulus; a seconds-level model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_wash_sequencer;

    typedef struct {
        int td, ft, wt, rt, spt, at, rn;
    } cfg_t;

    typedef struct {
        int st, rem, cnt, rl;
        bit paused, fault, done, washed;
    } mdl_t;

    localparam cfg_t CA = '{td: 4, ft: 5, wt: 3,   rt: 2, spt: 2, at: 1, rn: 1};
    localparam cfg_t CB = '{td: 2, ft: 5, wt: 100, rt: 2, spt: 2, at: 1, rn: 0};

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, waterfull = 1'b0;

    logic [2:0]  sa, sb;
    logic [5:0]  la, lb;
    logic [15:0] ba, bb;
    logic [3:0]  ra, rb;
    logic        pa, pb, fa, fb, da, db;
    logic [31:0] act_a, act_b;

    int tests = 0;
    int errors = 0;
    logic [31:0] qa[$], qb[$];
    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    always #5 clk = ~clk;

    wash_sequencer #(.TICK_DIV(4), .FILL_T(5), .WASH_T(3), .RINSE_T(2), .SPIN_T(2),
                     .ALARM_T(1), .RINSES(1)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .waterfull(waterfull), .state(sa), .state_led(la), .bcd(ba),
        .rinse_left(ra), .paused(pa), .fault(fa), .done(da));

    wash_sequencer #(.TICK_DIV(2), .FILL_T(5), .WASH_T(100), .RINSE_T(2), .SPIN_T(2),
                     .ALARM_T(1), .RINSES(0)) u_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .waterfull(waterfull), .state(sb), .state_led(lb), .bcd(bb),
        .rinse_left(rb), .paused(pb), .fault(fb), .done(db));

    assign act_a = {sa, la, ba, ra, pa, fa, da};
    assign act_b = {sb, lb, bb, rb, pb, fb, db};

    function automatic int dur(cfg_t c, int s);
        case (s)
            1: return c.ft;
            2: return c.wt;
            3: return c.rt;
            4: return c.spt;
            5: return c.at;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_dec_bcd(int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Seconds-remaining model: one call per clock edge.
    function automatic mdl_t step(mdl_t m, cfg_t c, bit rst, bit st_i, bit sp_i, bit pa_i, bit wf_i);
        mdl_t n;
        int   nxt;
        bit   tick;
        n = m;
        n.done = 0;
        if (rst) begin
            n = '{default: 0};
        end else if (sp_i && m.st != 0) begin
            n.st = 0; n.rem = 0; n.paused = 0; n.rl = 0; n.cnt = 0;
        end else if (m.st == 0) begin
            if (st_i) begin
                n.st = 1; n.rem = c.ft; n.rl = c.rn; n.cnt = 0;
                n.fault = 0; n.washed = 0; n.paused = 0;
            end
        end else begin
            nxt  = -1;
            tick = !m.paused && (m.cnt == c.td - 1);
            if (m.st == 1 && wf_i) nxt = m.washed ? 3 : 2;
            else if (tick && m.rem == 1) begin
                case (m.st)
                    1: begin nxt = 5; n.fault = 1; end
                    2: begin nxt = 4; n.washed = 1; end
                    3: begin nxt = 4; n.rl = m.rl - 1; end
                    4: nxt = (m.rl > 0) ? 1 : 5;
                    default: begin nxt = 0; n.done = !m.fault; end
                endcase
            end else if (tick) n.rem = m.rem - 1;
            if (nxt >= 0) begin
                n.st = nxt; n.rem = dur(c, nxt); n.cnt = 0;
            end else if (!m.paused) n.cnt = tick ? 0 : m.cnt + 1;
            if (pa_i) n.paused = !m.paused;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_of(mdl_t m);
        return {3'(m.st), 6'(1 << m.st), to_dec_bcd(m.rem), 4'(m.rl), m.paused, m.fault, m.done};
    endfunction

    always @(posedge clk) begin
        qa.push_back(exp_of(step(ma, CA, reset, start, stop, pause, waterfull)));
        qb.push_back(exp_of(step(mb, CB, reset, start, stop, pause, waterfull)));
        ma <= step(ma, CA, reset, start, stop, pause, waterfull);
        mb <= step(mb, CB, reset, start, stop, pause, waterfull);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got st=%0d led=%b bcd=%h rl=%0d p/f/d=%b exp st=%0d led=%b bcd=%h rl=%0d p/f/d=%b",
                     name, $time, act[31:29], act[28:23], act[22:7], act[6:3], act[2:0],
                     exp[31:29], exp[28:23], exp[22:7], exp[6:3], exp[2:0]);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0) chk("sb_a", act_a, qa.pop_front());
        if (qb.size() != 0) chk("sb_b", act_b, qb.pop_front());
    end

    task automatic timeout(string name);
        tests++;
        errors++;
        $display("FAIL timeout %s got state=%0d required event within bound", name, sa);
    endtask

    task automatic pulse(bit s, bit sp, bit p);
        @(negedge clk);
        start = s; stop = sp; pause = p;
        @(negedge clk);
        start = 0; stop = 0; pause = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; waterfull = 0;
        @(negedge clk);
        reset = 0;
    endtask

    // Raises waterfull two cycles into each FILL of instance A until A reaches target.
    task automatic run_until(int target, int bound, string name);
        int fill_cnt = 0;
        int n = 0;
        while (32'(sa) != target && n < bound) begin
            @(negedge clk);
            n++;
            if (sa == 3'd1) begin
                fill_cnt++;
                waterfull = (fill_cnt >= 2);
            end else begin
                fill_cnt = 0;
                waterfull = 0;
            end
        end
        waterfull = 0;
        if (32'(sa) != target) timeout(name);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;

        // nominal programme
        pulse(1, 0, 0);
        run_until(0, 300, "nominal");
        repeat (3) @(negedge clk);

        // fill timeout, then restart clears fault
        do_reset();
        pulse(1, 0, 0);
        repeat (40) @(negedge clk);
        pulse(1, 0, 0);
        repeat (3) @(negedge clk);
        pulse(0, 1, 0);

        // pause inside WASH
        do_reset();
        pulse(1, 0, 0);
        run_until(2, 100, "reach_wash");
        repeat (4) @(negedge clk);
        pulse(0, 0, 1);
        repeat (9) @(negedge clk);
        pulse(0, 0, 1);
        run_until(0, 300, "pause_finish");

        // stop coinciding with SPIN expiry, then start/stop/pause together in IDLE
        do_reset();
        pulse(1, 0, 0);
        run_until(4, 100, "reach_spin");
        repeat (6) @(negedge clk);
        pulse(0, 1, 0);
        repeat (2) @(negedge clk);
        pulse(1, 1, 1);
        repeat (3) @(negedge clk);
        pulse(0, 1, 0);

        // long wash on instance B exercises BCD borrow and RINSES=0
        do_reset();
        waterfull = 1;
        pulse(1, 0, 0);
        repeat (260) @(negedge clk);
        waterfull = 0;

        // reset while paused in RINSE
        do_reset();
        pulse(1, 0, 0);
        run_until(3, 200, "reach_rinse");
        pulse(0, 0, 1);
        do_reset();
        repeat (2) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(19) == 0);
            stop  = ($urandom_range(149) == 0);
            pause = ($urandom_range(39) == 0);
            reset = ($urandom_range(599) == 0);
            if ($urandom_range(7) == 0) waterfull = !waterfull;
        end
        @(negedge clk);
        start = 0; stop = 0; pause = 0; reset = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised wash-cycle sequencer: the next-generation controller for the washing-machine design. It runs the full programme FILL → WASH → SPIN → (FILL → RINSE → SPIN) × RINSES → ALARM → IDLE. All time-keeping comes from a single clock via an internal tick prescaler; no derived clocks are used. It exports the phase code, a one-hot LED vector and a 4-digit BCD countdown that feeds the existing dynamic-scan display path. New relative to the previous controller: programmable phase durations, a programmable rinse count, pause/resume, a fill-timeout fault, and a done pulse.

## Interface
- TICK_DIV, 24_000_000, clk cycles per one-second tick (≥2)
- FILL_T, 60, fill timeout in seconds (1..9999)
- WASH_T, 30, wash duration in seconds (1..9999)
- RINSE_T, 20, rinse duration in seconds (1..9999)
- SPIN_T, 10, spin (dewater) duration in seconds (1..9999)
- ALARM_T, 5, alarm duration in seconds (1..9999)
- RINSES, 2, number of rinse repetitions (0..15)
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  one-cycle pulse; starts a programme from IDLE
- stop  in  1  one-cycle pulse; aborts the programme
- pause  in  1  one-cycle pulse; toggles the pause flag
- waterfull  in  1  level; tank-full sensor
- state  out  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, ALARM=5
- state_led  out  6  one-hot, bit n set ⇔ state==n
- bcd  out  16  remaining seconds of the current phase, 4 BCD digits, [15:12] is the most significant
- rinse_left  out  4  rinse repetitions still to run
- paused  out  1  pause flag
- fault  out  1  fill timeout occurred
- done  out  1  one-cycle pulse when a programme completes normally

## Operation
- Reset values: state=IDLE, state_led=6'b000001, bcd=0, rinse_left=0, paused=0, fault=0, done=0, prescaler=0, washed flag=0.
- IDLE + start → FILL. The same edge loads bcd=FILL_T and rinse_left=RINSES, and clears fault, washed and paused. start is ignored outside IDLE.
- FILL + waterfull=1 → WASH (bcd=WASH_T) if washed=0, otherwise → RINSE (bcd=RINSE_T).
- FILL countdown expires → ALARM (bcd=ALARM_T) and set fault.
- WASH expires → SPIN (bcd=SPIN_T) and set washed.
- RINSE expires → SPIN and decrement rinse_left.
- SPIN expires → FILL (bcd=FILL_T) if rinse_left>0, otherwise → ALARM.
- ALARM expires → IDLE with bcd=0 and done=1 for that cycle. done stays 0 if fault is set.
- Countdown rule, applied on each tick in a non-paused, non-IDLE state:
  - bcd==1 → take the transition and load the next phase value.
  - otherwise → BCD decrement, e.g. 0100 → 0099.
  - A phase of T seconds therefore lasts exactly T ticks.
- pause toggles paused in any non-IDLE state. While paused, the prescaler and bcd hold. The waterfull exit from FILL is still honoured while paused, and paused stays set across that transition. pause in IDLE is ignored.
- stop in any non-IDLE state → IDLE next cycle: bcd=0, paused=0, rinse_left=0, done=0. fault keeps its value.
- Priority when events coincide: reset > stop > waterfull/tick transition > pause. A pause in the same cycle as a phase transition still toggles paused.
- state_led is decoded combinationally from registered state.

## Timing
- All outputs are registered except state_led.
- Response latency: an input sampled at edge k produces its effect at edge k, visible the cycle after.
- Prescaler:
  - Counts 0..TICK_DIV-1; the tick fires on the cycle where count==TICK_DIV-1.
  - Resets to 0 on every state change, so the first tick of a phase comes TICK_DIV cycles after entry.
  - A phase of T seconds with no pause therefore spans T·TICK_DIV cycles.
- Pause: the prescaler holds its count, so resuming continues the partial second with nothing lost.
- Reset mid-operation: all state returns to reset values on the next edge regardless of other inputs.

## Structure
- Shared package wash_pkg:
  - state encoding constants (IDLE..ALARM)
  - state width 3
  - BCD digit width 4
  - helper function converting an integer parameter to 16-bit BCD, used at elaboration for the load values
- Sub-module bcd_down4:
  - 4-digit BCD register with synchronous load, decrement enable and an is_one flag
  - decrement ripples borrow per digit (0→9 with borrow)
  - instantiated once
- Top-level holds the FSM, prescaler, washed flag and rinse counter.

## Test plan
All scenarios use TICK_DIV=4, FILL_T=5, WASH_T=3, RINSE_T=2, SPIN_T=2, ALARM_T=1, RINSES=1 unless stated.
- Nominal run: start; waterfull asserted 2 cycles after entering each FILL → state sequence 1,2,4,1,3,4,5,0. WASH occupies exactly 12 cycles. bcd in WASH reads 3,2,1. rinse_left goes 1→0 on RINSE exit. done pulses once for 1 cycle; fault=0.
- Fill timeout: start with waterfull held 0 → ALARM after 20 cycles in FILL; fault=1; IDLE after 4 more cycles with done=0. Next start clears fault.
- Pause: pause 5 cycles into WASH, hold 10 cycles, pause again → bcd frozen at 2 and prescaler frozen while paused. WASH total = 12 + 10 cycles.
- Stop priority: stop and the expiry tick coincide in SPIN → IDLE next cycle, bcd=0, done=0. start, stop and pause in the same IDLE cycle → state goes to FILL.
- RINSES=0 and BCD borrow (WASH_T=100, TICK_DIV=2) → WASH → SPIN → ALARM with no second FILL. bcd steps 0100→0099 with correct borrow.
- Reset mid-RINSE with paused=1 → all outputs at reset values on the next cycle; state_led=000001.
